// File: rtl/timer_display.sv
// Chess-clock display driver: multiplexes white/black remaining time onto an 8-digit 7-segment display.
// Optional macro TIMER_DISPLAY_BLINK_EN blinks the digits of a side whose time has expired.
module timer_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] countdownWhite,
  input  logic [9:0] countdownBlack,
  input  logic       turn,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       flagWhite,
  output logic       flagBlack
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONV, DONE} bcd_state_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          snap;

  // Side index 0 = black, 1 = white, matching idx_q[2].
  logic [9:0]    cd      [2];
  logic [5:0]    sec_in  [2];
  bcd_state_e    st_q    [2];
  logic [5:0]    work_q  [2];
  logic [2:0]    twork_q [2];
  logic [2:0]    msnap_q [2];
  logic [2:0]    tens_q  [2];
  logic [3:0]    units_q [2];
  logic [2:0]    mins_q  [2];
  logic          flag_q  [2];

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          sd;
  logic [3:0]    digit_val;
  logic          dash, blank, hide;
  logic          unused_bit9;

  assign cd[0] = countdownBlack;
  assign cd[1] = countdownWhite;
  assign unused_bit9 = ^{countdownWhite[9], countdownBlack[9]};

  assign snap = (cnt_q == '0) && (idx_q == '0);

  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      sec_in[s] = (cd[s][5:0] > 6'd59) ? 6'd59 : cd[s][5:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Both sides share one FSM block; each converts by repeated subtraction of 10.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        st_q[s]    <= IDLE;
        work_q[s]  <= '0;
        twork_q[s] <= '0;
        msnap_q[s] <= '0;
        tens_q[s]  <= '0;
        units_q[s] <= '0;
        mins_q[s]  <= '0;
        flag_q[s]  <= 1'b0;
      end
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (snap && (cd[s][8:0] == '0)) flag_q[s] <= 1'b1;
        case (st_q[s])
          IDLE: begin
            if (snap) begin
              work_q[s]  <= sec_in[s];
              twork_q[s] <= '0;
              msnap_q[s] <= cd[s][8:6];
              st_q[s]    <= CONV;
            end
          end
          CONV: begin
            if (work_q[s] >= 6'd10) begin
              work_q[s]  <= work_q[s] - 6'd10;
              twork_q[s] <= twork_q[s] + 3'd1;
            end else begin
              st_q[s] <= DONE;
            end
          end
          DONE: begin
            tens_q[s]  <= twork_q[s];
            units_q[s] <= work_q[s][3:0];
            mins_q[s]  <= msnap_q[s];
            st_q[s]    <= IDLE;
          end
          default: st_q[s] <= IDLE;
        endcase
      end
    end
  end

`ifdef TIMER_DISPLAY_BLINK_EN
  logic [23:0] blink_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) blink_q <= '0;
    else      blink_q <= blink_q + 24'd1;
  end

  assign hide = flag_q[sd] && blink_q[23] && (idx_q[1:0] != 2'd3);
`else
  assign hide = 1'b0;
`endif

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign sd = idx_q[2];

  always_comb begin
    digit_val = '0;
    dash      = 1'b0;
    blank     = 1'b0;
    case (idx_q[1:0])
      2'd3: begin
        dash  = (turn == ~idx_q[2]);
        blank = ~dash;
      end
      2'd2:    digit_val = {1'b0, mins_q[sd]};
      2'd1:    digit_val = {1'b0, tens_q[sd]};
      default: digit_val = units_q[sd];
    endcase
    if (blank || hide) seg_d = 7'h7F;
    else if (dash)     seg_d = 7'h3F;
    else               seg_d = seg_enc(digit_val);
    dp_d = ~((idx_q[1:0] == 2'd2) && !hide);
    an_d = ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign flagWhite = flag_q[1];
  assign flagBlack = flag_q[0];

endmodule

// File: doc/timer_display.md
TIMER_DISPLAY -- requirements
Module: timer_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit; legal range 16..2^20.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 countdownWhite  input  10  white time: [8:6] minutes, [5:0] seconds, [9] ignored.
REQ-005 countdownBlack  input  10  black time, same packing.
REQ-006 turn  input  1  side to move: 1 black, 0 white.
REQ-007 an  output  8  digit enables, active-low; an[7:4] white, an[3:0] black.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp  output  1  decimal point, active-low, used as minute/second colon.
REQ-010 flagWhite / flagBlack  output  1 each  sticky time-expired flags.

Function
REQ-011 Refresh counter counts 0..REFRESH_DIV-1 then wraps; on wrap, scan index (0..7) increments, 7 wraps to 0.
REQ-012 Exactly one an bit low at any time after reset: an[idx] low; all others high.
REQ-013 Per side, digit 3 = turn marker, digit 2 = minutes, digit 1 = seconds tens, digit 0 = seconds units.
REQ-014 Turn marker shows dash (only g lit) on the side to move, blank (all seg high) on the other; turn sampled live, not snapshotted.
REQ-015 dp low only while digit 2 of either side is enabled; high otherwise.
REQ-016 Snapshot: both inputs and seconds values registered when refresh counter==0 and idx==0; no input change visible mid-frame.
REQ-017 Seconds field >59 clamps to 59 at snapshot.
REQ-018 Binary-to-BCD per side via sequential FSM: IDLE -> CONV (subtract 10 per cycle, tens++, while value>=10) -> DONE -> IDLE; both sides converted in parallel.
REQ-019 Conversion completes within 7 cycles of snapshot; display registers (tens, units, minutes) update only in DONE, so old frame values persist until then.
REQ-020 Segment encoding: standard 0-9 hex patterns; seg is registered, one cycle latency from idx/digit data change.
REQ-021 flagX set in the cycle after a snapshot where that side's minutes==0 and seconds==0; cleared only by reset.
REQ-022 Both flags may set in the same cycle; no priority.
REQ-023 Snapshot coinciding with an in-progress conversion (impossible for REFRESH_DIV>=16) is not required to be handled.

Reset
REQ-024 While rst low: an=8'hFF, seg=7'h7F, dp=1, flagWhite=flagBlack=0, refresh counter=0, idx=0, FSMs IDLE, snapshot and BCD registers 0.
REQ-025 First snapshot taken on the first rising clk edge after rst deasserts; reset asserted mid-conversion aborts it immediately.

Configuration
REQ-026 Macro TIMER_DISPLAY_BLINK_EN defined: digits of a flagged side (digits 2..0 and its dp) blank during the upper half of a 2^24-cycle free-running blink counter, cleared by reset.
REQ-027 Macro undefined: no blink counter; flagged side digits always shown (0:00).

Verification (REFRESH_DIV=16)
REQ-028 Release rst, white=0x17B (5:59), black=0x13C (4:60) -> frame shows white "5.59", black "4.59".
REQ-029 Hold rst low 20 cycles -> an=FF, seg=7F, dp=1, flags 0; after release an cycles FE,FD,...,7F each 16 cycles.
REQ-030 turn toggled 0->1 mid-frame -> dash moves from an[7] digit to an[3] digit on next visit, no other digit changes.
REQ-031 Change white input mid-frame -> displayed value changes only after next idx==0 snapshot plus <=7 cycles.
REQ-032 Drive black=0x000 -> flagBlack=1 one cycle after snapshot; restore black=0x17B -> flagBlack stays 1 until rst.
REQ-033 Both sides 0x000 simultaneously -> both flags set in the same cycle; with TIMER_DISPLAY_BLINK_EN, both sides' digits blank during blink half.
